// File: rtl/residual_zigzag_scanner.sv
// Residual zigzag scanner: latches one luma macroblock of quantized levels
// (16 DC levels + 16 AC blocks) and streams them in VP8 zigzag order, one
// coefficient per valid/ready beat, trimming each block after its last
// nonzero position and emitting a single empty-marker beat for empty blocks.
module residual_zigzag_scanner #(
   parameter int BLOCK_SIZE = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [BLOCK_SIZE*16-1:0]     Y_dc_levels,
   input  logic [BLOCK_SIZE*256-1:0]    Y_ac_levels,
   output logic                         busy,
   output logic                         coef_valid,
   input  logic                         coef_ready,
   output logic [15:0]                  coef_data,
   output logic [4:0]                   coef_blk,
   output logic [3:0]                   coef_idx,
   output logic                         coef_last,
   output logic                         coef_empty,
   output logic [16:0]                  nz_mask,
   output logic                         done
);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

   state_t      state, state_n;
   logic [15:0] dc_reg [BLOCK_SIZE];
   logic [15:0] ac_reg [BLOCK_SIZE][BLOCK_SIZE];
   logic [4:0]  blk;
   logic [3:0]  pos;

   logic [15:0] sel [BLOCK_SIZE];
   logic [3:0]  last_p;
   logic        any_nz;
   logic        cur_last;
   logic        hs;
   logic [16:0] nz_in;

   // Zigzag position to raster index.
   function automatic logic [3:0] zz(input logic [3:0] p);
      case (p)
         4'd0:  zz = 4'd0;
         4'd1:  zz = 4'd1;
         4'd2:  zz = 4'd4;
         4'd3:  zz = 4'd8;
         4'd4:  zz = 4'd5;
         4'd5:  zz = 4'd2;
         4'd6:  zz = 4'd3;
         4'd7:  zz = 4'd6;
         4'd8:  zz = 4'd9;
         4'd9:  zz = 4'd12;
         4'd10: zz = 4'd13;
         4'd11: zz = 4'd10;
         4'd12: zz = 4'd7;
         4'd13: zz = 4'd11;
         4'd14: zz = 4'd14;
         default: zz = 4'd15;
      endcase
   endfunction

   // Nonzero flags of the incoming macroblock (AC level k=0 excluded).
   always_comb begin
      nz_in = '0;
      for (int unsigned b = 0; b < BLOCK_SIZE; b++) begin
         if (Y_dc_levels[16*b +: 16] != '0) nz_in[16] = 1'b1;
         for (int unsigned k = 1; k < BLOCK_SIZE; k++) begin
            if (Y_ac_levels[16*(16*b+k) +: 16] != '0) nz_in[b] = 1'b1;
         end
      end
   end

   // Select the current block and priority-encode its last nonzero position.
   always_comb begin
      last_p = '0;
      any_nz = 1'b0;
      for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
         sel[i] = blk[4] ? dc_reg[i] : ac_reg[blk[3:0]][i];
      end
      for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
         if ((blk[4] || i != 0) && sel[zz(4'(i))] != '0) begin
            last_p = 4'(i);
            any_nz = 1'b1;
         end
      end
   end

   // Beat outputs decoded purely from registered state and latched levels.
   always_comb begin
      coef_valid = (state == ST_SCAN);
      cur_last   = !any_nz || (pos == last_p);
      coef_last  = coef_valid && cur_last;
      coef_empty = coef_valid && !any_nz;
      coef_data  = (coef_valid && any_nz) ? sel[zz(pos)] : '0;
      coef_blk   = blk;
      coef_idx   = pos;
      hs         = coef_valid && coef_ready;
      busy       = (state != ST_IDLE);
      done       = (state == ST_DONE);
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (start) state_n = ST_SCAN;
         ST_SCAN: if (hs && cur_last && blk == 5'd15) state_n = ST_DONE;
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // Level latch, mask, and block/position scan counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk     <= '0;
         pos     <= '0;
         nz_mask <= '0;
         for (int unsigned b = 0; b < BLOCK_SIZE; b++) begin
            dc_reg[b] <= '0;
            for (int unsigned k = 0; k < BLOCK_SIZE; k++) ac_reg[b][k] <= '0;
         end
      end else if (state == ST_IDLE && start) begin
         blk     <= 5'd16;
         pos     <= '0;
         nz_mask <= nz_in;
         for (int unsigned b = 0; b < BLOCK_SIZE; b++) begin
            dc_reg[b] <= Y_dc_levels[16*b +: 16];
            for (int unsigned k = 0; k < BLOCK_SIZE; k++)
               ac_reg[b][k] <= Y_ac_levels[16*(16*b+k) +: 16];
         end
      end else if (hs) begin
         if (cur_last) begin
            if (blk != 5'd15) begin
               blk <= blk[4] ? 5'd0 : blk + 5'd1;
               pos <= 4'd1;
            end
         end else begin
            pos <= pos + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_residual_zigzag_scanner.sv
// Testbench for residual_zigzag_scanner: a reference zigzag model fills a
// scoreboard per macroblock; a negedge monitor pops and compares each beat.
module tb_residual_zigzag_scanner;

   typedef struct packed {
      logic [15:0] data;
      logic [4:0]  blk;
      logic [3:0]  idx;
      logic        last;
      logic        empty;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [255:0]  Y_dc_levels = '0;
   logic [4095:0] Y_ac_levels = '0;
   logic          busy, coef_valid, coef_last, coef_empty, done;
   logic          coef_ready = 1'b0;
   logic [15:0]   coef_data;
   logic [4:0]    coef_blk;
   logic [3:0]    coef_idx;
   logic [16:0]   nz_mask;

   residual_zigzag_scanner #(.BLOCK_SIZE(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .Y_dc_levels(Y_dc_levels), .Y_ac_levels(Y_ac_levels),
      .busy(busy), .coef_valid(coef_valid), .coef_ready(coef_ready),
      .coef_data(coef_data), .coef_blk(coef_blk), .coef_idx(coef_idx),
      .coef_last(coef_last), .coef_empty(coef_empty),
      .nz_mask(nz_mask), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int s_cyc = 0;
   int beats_seen = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   bit done_seen = 0;
   bit hold_chk = 0;
   beat_t held;
   beat_t sb[$];
   int exp_n;
   logic [16:0] exp_mask;

   logic [15:0] dc_s [16];
   logic [15:0] ac_s [16][16];
   int zz_t [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: done tracking, stall stability, scoreboard comparison.
   always @(negedge clk) begin
      beat_t got, e;
      got = beat_t'({coef_data, coef_blk, coef_idx, coef_last, coef_empty});
      if (rst) begin
         hold_chk = 0;
      end else begin
         if (done) begin
            done_seen = 1;
            done_cnt++;
            done_cyc = cyc - s_cyc + 1;
         end
         if (hold_chk) begin
            checks++;
            if (!coef_valid || got !== held) begin
               failures++;
               $display("FAIL stall_hold: got valid=%0b beat=%h required valid=1 beat=%h",
                        coef_valid, got, held);
            end
         end
         if (coef_valid && coef_ready) begin
            beats_seen++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL extra_beat: got beat=%h required no beat", got);
            end else begin
               e = sb.pop_front();
               if (got !== e) begin
                  failures++;
                  $display("FAIL beat: got data=%h blk=%0d idx=%0d last=%0b empty=%0b required data=%h blk=%0d idx=%0d last=%0b empty=%0b",
                           got.data, got.blk, got.idx, got.last, got.empty,
                           e.data, e.blk, e.idx, e.last, e.empty);
               end
            end
         end
         hold_chk = coef_valid && !coef_ready;
         held = got;
      end
   end

   task automatic clear_levels();
      for (int b = 0; b < 16; b++) begin
         dc_s[b] = '0;
         for (int k = 0; k < 16; k++) ac_s[b][k] = '0;
      end
   endtask

   task automatic random_levels(input int blk_pct);
      for (int b = 0; b < 16; b++) begin
         bit act_dc, act_ac;
         act_dc = ($urandom_range(99) < blk_pct);
         act_ac = ($urandom_range(99) < blk_pct);
         for (int k = 0; k < 16; k++) begin
            dc_s[b] = (act_dc && $urandom_range(99) < 25) ? 16'($urandom) : 16'h0;
            ac_s[b][k] = (act_ac && $urandom_range(99) < 25) ? 16'($urandom) : 16'h0;
         end
      end
      // keep an extreme value in play
      ac_s[$urandom_range(15)][$urandom_range(15)] = 16'h8000;
   endtask

   task automatic build_expect();
      sb.delete();
      exp_n = 0;
      exp_mask = '0;
      for (int o = 0; o < 17; o++) begin
         int blkn, first, last;
         logic [15:0] lvl [16];
         blkn  = (o == 0) ? 16 : o - 1;
         first = (blkn == 16) ? 0 : 1;
         for (int i = 0; i < 16; i++) lvl[i] = (blkn == 16) ? dc_s[i] : ac_s[blkn][i];
         last = -1;
         for (int p = first; p < 16; p++) if (lvl[zz_t[p]] != 0) last = p;
         if (last >= 0) exp_mask[blkn] = 1'b1;
         if (last < 0) begin
            sb.push_back(beat_t'({16'h0, 5'(blkn), 4'(first), 1'b1, 1'b1}));
            exp_n++;
         end else begin
            for (int p = first; p <= last; p++) begin
               sb.push_back(beat_t'({lvl[zz_t[p]], 5'(blkn), 4'(p), 1'(p == last), 1'b0}));
               exp_n++;
            end
         end
      end
   endtask

   task automatic drive_buses();
      for (int b = 0; b < 16; b++) begin
         Y_dc_levels[16*b +: 16] = dc_s[b];
         for (int k = 0; k < 16; k++) Y_ac_levels[16*(16*b+k) +: 16] = ac_s[b][k];
      end
   endtask

   task automatic scramble_buses();
      for (int w = 0; w < 8; w++) Y_dc_levels[32*w +: 32] = $urandom;
      for (int w = 0; w < 128; w++) Y_ac_levels[32*w +: 32] = $urandom;
   endtask

   task automatic issue_start();
      build_expect();
      drive_buses();
      beats_seen = 0;
      done_seen = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      s_cyc = cyc;
      start = 1'b0;
      scramble_buses();
   endtask

   // One macroblock: start, stream with optional stalls, wait for done.
   task automatic run_mb(input int stall_pct, input bit inject_start, input int want_beats);
      coef_ready = (stall_pct == 0) ? 1'b1 : 1'($urandom_range(99) >= stall_pct);
      issue_start();
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || coef_valid !== 1'b1) begin
         failures++;
         $display("FAIL first_cycle: got busy=%0b valid=%0b required busy=1 valid=1", busy, coef_valid);
      end
      checks++;
      if (nz_mask !== exp_mask) begin
         failures++;
         $display("FAIL nz_mask: got %h required %h", nz_mask, exp_mask);
      end
      for (int k = 0; k < 3000 && !done_seen; k++) begin
         @(posedge clk);
         #1;
         if (stall_pct != 0) coef_ready = 1'($urandom_range(99) >= stall_pct);
         if (inject_start && k == 5) scramble_buses();
         start = (inject_start && k == 5);
      end
      start = 1'b0;
      checks++;
      if (!done_seen) begin
         failures++;
         $display("FAIL done_timeout: got no done required done");
      end
      if (stall_pct == 0) begin
         checks++;
         if (done_cyc != exp_n + 1) begin
            failures++;
            $display("FAIL done_cycle: got %0d required %0d", done_cyc, exp_n + 1);
         end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL after_done: got busy=%0b done=%0b required 0 0", busy, done);
      end
      checks++;
      if (sb.size() != 0 || (want_beats >= 0 && beats_seen != want_beats)) begin
         failures++;
         $display("FAIL beat_count: got beats=%0d left=%0d required beats=%0d left=0",
                  beats_seen, sb.size(), (want_beats >= 0) ? want_beats : exp_n);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, coef_valid, coef_data, coef_blk, coef_idx, coef_last, coef_empty, nz_mask, done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got busy=%0b valid=%0b data=%h blk=%0d idx=%0d mask=%h done=%0b required all 0",
                  busy, coef_valid, coef_data, coef_blk, coef_idx, nz_mask, done);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_all_zero();
      clear_levels();
      run_mb(0, 0, 17);
   endtask

   task automatic test_dc_edges();
      clear_levels();
      dc_s[0]  = 16'd5;
      dc_s[15] = 16'hFFFD;
      run_mb(0, 0, 32);
   endtask

   task automatic test_ac_last();
      clear_levels();
      ac_s[3][15] = 16'd7;
      run_mb(0, 0, 31);
   endtask

   task automatic test_ac_interior();
      clear_levels();
      ac_s[0][4] = 16'hFFFF;
      ac_s[5][0] = 16'd9;   // raster 0 of an AC block is outside the scan
      run_mb(0, 0, 18);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         random_levels(60);
         run_mb(35, 1, -1);
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 2; r++) begin
         random_levels(50);
         run_mb(0, 0, -1);
      end
   endtask

   task automatic test_mid_reset();
      int snap;
      random_levels(80);
      coef_ready = 1'b1;
      issue_start();
      for (int k = 0; k < 200 && beats_seen < 10; k++) begin
         @(negedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      checks++;
      if (coef_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got valid=%0b busy=%0b required 0 0", coef_valid, busy);
      end
      snap = done_cnt;
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if (done_cnt != snap || busy !== 1'b0) begin
         failures++;
         $display("FAIL no_done_after_reset: got done_pulses=%0d busy=%0b required 0 0", done_cnt - snap, busy);
      end
      run_mb(0, 0, -1);
   endtask

   initial begin
      test_reset();
      test_all_zero();
      test_dc_edges();
      test_ac_last();
      test_ac_interior();
      test_random();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
